// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Latency: none, this file holds only declarations.
// Backpressure: none, this file holds only declarations.
package disp_pkg;

    typedef logic [6:0]       seg_t;
    typedef logic [7:0][6:0]  frame_t;

    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/disp_scan.sv
// Scan engine: time-multiplexes an 8-digit frame onto active-low AN/A2G pins.
// Latency: pins are registered, one cycle behind en/cur/digit; optional dead time via DISP_ARB_BLANK_EN.
// Backpressure: none; the scan free-runs from reset and samples cur every cycle.
module disp_scan
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 4
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       en,
    input  frame_t     cur,
    output logic [7:0] AN,
    output seg_t       A2G
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

`ifdef DISP_ARB_BLANK_EN
    localparam logic BLANK_ON = 1'b1;
`else
    localparam logic BLANK_ON = 1'b0;
`endif

    logic [PW-1:0] presc;
    logic [2:0]    digit;
    logic          blank;

    // Dead time at the start of each slot keeps the previous digit from ghosting.
    assign blank = BLANK_ON && (presc < PW'(BLANK_CYC));

    // Prescaler and digit index run continuously, independent of ownership.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            presc <= '0;
            digit <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            digit <= digit + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Pin registers: dark when unowned or blanking, else the current digit of the owner frame.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            AN  <= AN_OFF;
            A2G <= SEG_BLANK;
        end else if (en && !blank) begin
            AN  <= ~(8'h01 << digit);
            A2G <= cur[digit];
        end else begin
            AN  <= AN_OFF;
            A2G <= SEG_BLANK;
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin display owner arbiter with minimum dwell, driving the scan engine.
// Latency: grant one edge after req; pins one edge after grant. Optional blanking: DISP_ARB_BLANK_EN.
// Backpressure: requesters hold req level; the owner keeps the display until it drops or is preempted after DWELL.
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int SCAN_DIV  = 100000,
    parameter int DWELL     = 100000000,
    parameter int BLANK_CYC = 4
) (
    input  logic                       CLK100MHZ,
    input  logic                       CPU_RESETN,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][7:0][6:0]  frame,
    output logic [NREQ-1:0]            grant,
    output logic                       busy,
    output logic [7:0]                 AN,
    output logic [6:0]                 A2G
);

    localparam int OW   = $clog2(NREQ);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    arb_state_e      state_q, state_d;
    logic [OW-1:0]   own_q, own_d;
    logic [OW-1:0]   last_q, last_d;
    logic [DW_W-1:0] dw_q, dw_d;

    logic [NREQ-1:0] own_oh;
    logic [NREQ-1:0] others;
    logic            expired;
    logic            leave;
    logic [OW-1:0]   srch_base;
    logic [NREQ-1:0] srch_mask;
    logic            found;
    logic [OW-1:0]   found_idx;
    int              c;
    frame_t          cur;

    assign own_oh  = NREQ'(1) << own_q;
    assign others  = req & ~own_oh;
    assign expired = (dw_q == DW_W'(DWELL - 1));
    assign leave   = (state_q == OWN) && (!req[own_q] || (expired && (|others)));

    assign grant = (state_q == OWN) ? own_oh : '0;
    assign busy  = (state_q == OWN);
    assign cur   = frame[own_q];

    // Round-robin search: first set bit after the base index, wrapping; the current owner is masked out when leaving.
    always_comb begin
        srch_base = (state_q == IDLE) ? last_q : own_q;
        srch_mask = (state_q == IDLE) ? req : others;
        found     = 1'b0;
        found_idx = '0;
        c         = 0;
        for (int i = 1; i <= NREQ; i++) begin
            c = int'(srch_base) + i;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!found && srch_mask[c[OW-1:0]]) begin
                found     = 1'b1;
                found_idx = c[OW-1:0];
            end
        end
    end

    // Next-state: grant from idle, hand over directly on drop or preemption, otherwise count dwell.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        dw_d    = dw_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    own_d   = found_idx;
                    last_d  = found_idx;
                    dw_d    = '0;
                end
            end
            OWN: begin
                if (leave) begin
                    if (found) begin
                        own_d  = found_idx;
                        last_d = found_idx;
                        dw_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!expired) begin
                    dw_d = dw_q + DW_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            own_q   <= '0;
            last_q  <= OW'(NREQ - 1);
            dw_q    <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            dw_q    <= dw_d;
        end
    end

    disp_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scan (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .en         (busy),
        .cur        (cur),
        .AN         (AN),
        .A2G        (A2G)
    );

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: randomized and directed requests against a cycle-level reference model.
// Latency: expectations are queued at each rising edge and compared at the following falling edge.
// Backpressure: none; the monitor consumes one expectation per cycle.
module tb_disp_arbiter;

    localparam int NREQ      = 3;
    localparam int SCAN_DIV  = 4;
    localparam int DWELL     = 8;
    localparam int BLANK_CYC = 1;

`ifdef DISP_ARB_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic [NREQ-1:0]           req;
    logic [NREQ-1:0][7:0][6:0] frame;
    logic [NREQ-1:0]           grant;
    logic                      busy;
    logic [7:0]                AN;
    logic [6:0]                A2G;

    disp_arbiter #(
        .NREQ      (NREQ),
        .SCAN_DIV  (SCAN_DIV),
        .DWELL     (DWELL),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .req        (req),
        .frame      (frame),
        .grant      (grant),
        .busy       (busy),
        .AN         (AN),
        .A2G        (A2G)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] g;
        logic [7:0]      an;
        logic [6:0]      seg;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushes   = 0;
    int   pops     = 0;

    // Reference model state: owner (-1 = nobody), cycles held, most recent owner, edges since reset.
    int m_own  = -1;
    int m_held = 0;
    int m_last = NREQ - 1;
    int m_k    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
        end
    endtask

    function automatic int rr_pick(input int base, input logic [NREQ-1:0] mask);
        for (int i = 1; i <= NREQ; i++) begin
            if (mask[(base + i) % NREQ]) return (base + i) % NREQ;
        end
        return -1;
    endfunction

    // Model: at each edge derive the pins from the pre-edge owner and scan position, then re-arbitrate.
    always @(posedge clk) begin : model
        exp_t            e;
        int              d;
        int              p;
        logic [NREQ-1:0] oth;
        if (!rst_n) begin
            m_own  = -1;
            m_held = 0;
            m_last = NREQ - 1;
            m_k    = 0;
        end else begin
            d = (m_k / SCAN_DIV) % 8;
            p = m_k % SCAN_DIV;
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            if (m_own >= 0 && !(BLANK && p < BLANK_CYC)) begin
                e.an  = ~(8'h01 << d);
                e.seg = frame[m_own][d];
            end
            if (m_own < 0) begin
                m_own = rr_pick(m_last, req);
                if (m_own >= 0) begin
                    m_held = 1;
                    m_last = m_own;
                end
            end else begin
                oth = req & ~(NREQ'(1) << m_own);
                if (!req[m_own] || (m_held >= DWELL && oth != '0)) begin
                    m_own = rr_pick(m_own, oth);
                    if (m_own >= 0) begin
                        m_held = 1;
                        m_last = m_own;
                    end
                end else begin
                    m_held++;
                end
            end
            m_k++;
            e.g = (m_own >= 0) ? (NREQ'(1) << m_own) : '0;
            exp_q.push_back(e);
            pushes++;
        end
    end

    // Monitor: compare on the falling edge; during reset everything must be dark.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_busy",  32'(busy),  32'h0);
            chk("rst_an",    32'(AN),    32'hFF);
            chk("rst_a2g",   32'(A2G),   32'h7F);
            pops = pops + exp_q.size();
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pops++;
            chk("grant", 32'(grant), 32'(e.g));
            chk("busy",  32'(busy),  32'(|e.g));
            chk("an",    32'(AN),    32'(e.an));
            chk("a2g",   32'(A2G),   32'(e.seg));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        for (int r = 0; r < NREQ; r++)
            for (int d = 0; d < 8; d++)
                frame[r][d] = 7'($urandom);

        // Reset held for three edges, then idle and dark.
        cyc(3);
        rst_n = 1'b1;
        cyc(64);

        // Single owner walking all digits with a recognisable frame.
        for (int d = 0; d < 8; d++) frame[0][d] = 7'(d);
        req = 3'b001;
        cyc(40);
        req = 3'b000;
        cyc(6);

        // Two requesters alternate every DWELL cycles.
        req = 3'b011;
        cyc(40);
        req = 3'b000;
        cyc(4);

        // Competitor arrives mid-dwell; no early preemption.
        req = 3'b001;
        cyc(4);
        req = 3'b011;
        cyc(20);
        req = 3'b000;
        cyc(4);

        // Owner drops in the same cycle another requester rises.
        req = 3'b001;
        cyc(3);
        req = 3'b100;
        cyc(6);

        // Asynchronous reset mid-ownership must darken the pins before any edge.
        req = 3'b001;
        cyc(6);
        rst_n = 1'b0;
        #1;
        chk("async_an",    32'(AN),    32'hFF);
        chk("async_a2g",   32'(A2G),   32'h7F);
        chk("async_grant", 32'(grant), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        req   = 3'b000;
        cyc(4);

        // Randomized requests and live frame updates.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0)
                frame[$urandom_range(0, NREQ-1)][$urandom_range(0, 7)] = 7'($urandom);
            cyc(1);
        end

        req = '0;
        cyc(4);
        @(negedge clk);
        #1;
        chk("drain", 32'(pops), 32'(pushes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
